pixel_plotter: RTL and testbench

PIXEL_PLOTTER -- requirements
Module: pixel_plotter

---
 rtl/pixel_plotter.sv | 166 ++++++++++++++++
 tb/tb_pixel_plotter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plotter.sv
// pixel_plotter: filters a pixel stream (clip / duplicate), queues framebuffer
// writes in a small FIFO and drains them one per MEM_ACK.
module pixel_plotter #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              PIX_VALID,
  input  logic [7:0]        PIX_X,
  input  logic [7:0]        PIX_Y,
  input  logic [7:0]        PIX_COLOR,
  input  logic              PIX_LAST,
  output logic              PIX_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_DATA,
  input  logic              MEM_ACK,
  output logic              DONE,
  output logic [15:0]       WR_CNT,
  output logic [15:0]       CLIP_CNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 10;

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t             r_state, w_next_state;
  logic [ENT_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_rdy_en;
  logic               r_prev_valid;
  logic [7:0]         r_prev_x, r_prev_y;
  logic               r_we, r_done, r_cur_last;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_data;
  logic [15:0]        r_wr_cnt, r_clip_cnt;

  logic               w_full, w_empty, w_accept, w_clip, w_dup, w_wr, w_push;
  logic [ADDR_W-1:0]  w_addr;
  logic [ENT_W-1:0]   w_din, w_head;
  logic               w_head_wr, w_head_last;
  logic               w_pop, w_load, w_done_next, w_inc_wr;

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign PIX_READY = r_rdy_en & ~w_full;
  assign w_accept  = PIX_VALID & PIX_READY;

  assign w_clip = (32'(PIX_X) >= H_RES) | (32'(PIX_Y) >= V_RES);
  assign w_dup  = r_prev_valid & ~w_clip & (PIX_X == r_prev_x) & (PIX_Y == r_prev_y);
  assign w_wr   = ~w_clip & ~w_dup;
  // Dropped pixels still push a marker when they end a primitive so DONE is not lost.
  assign w_push = w_accept & (w_wr | PIX_LAST);
  assign w_addr = ADDR_W'(PIX_Y) * ADDR_W'(H_RES) + ADDR_W'(PIX_X);
  assign w_din  = {w_addr, PIX_COLOR, PIX_LAST, w_wr};

  assign w_head      = r_fifo[r_rptr];
  assign w_head_wr   = w_head[0];
  assign w_head_last = w_head[1];

  always_ff @(posedge ACLK) begin
    if (w_push) r_fifo[r_wptr] <= w_din;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_prev_valid <= 1'b0;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_clip_cnt   <= '0;
    end else if (w_accept) begin
      r_prev_valid <= ~PIX_LAST;
      r_prev_x     <= PIX_X;
      r_prev_y     <= PIX_Y;
      if (w_clip && r_clip_cnt != 16'hFFFF) r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_done_next  = 1'b0;
    w_inc_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_wr) begin
            w_load       = 1'b1;
            w_next_state = S_WRITE;
          end else begin
            w_done_next = w_head_last;
          end
        end
      end
      S_WRITE: begin
        if (MEM_ACK) begin
          w_inc_wr    = 1'b1;
          w_done_next = r_cur_last;
          // A queued marker is left for IDLE so its DONE cannot collide with this one.
          if (!w_empty && w_head_wr) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_cur_last <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_we    <= (w_next_state == S_WRITE);
      r_done  <= w_done_next;
      if (w_load) begin
        r_addr     <= w_head[ENT_W-1 -: ADDR_W];
        r_data     <= w_head[9:2];
        r_cur_last <= w_head_last;
      end
      if (w_inc_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign MEM_WE   = r_we;
  assign MEM_ADDR = r_addr;
  assign MEM_DATA = r_data;
  assign DONE     = r_done;
  assign WR_CNT   = r_wr_cnt;
  assign CLIP_CNT = r_clip_cnt;

endmodule

// File: tb/tb_pixel_plotter.sv
// tb_pixel_plotter: directed stimulus for pixel_plotter with a transaction-level
// model (expected-write queue) checked every cycle, plus literal checks.
module tb_pixel_plotter;

  localparam int HRES = 160;
  localparam int VRES = 120;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic [7:0]  PIX_X = '0, PIX_Y = '0, PIX_COLOR = '0;
  logic        PIX_LAST = 1'b0;
  logic        PIX_READY;
  logic        MEM_WE;
  logic [14:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        MEM_ACK = 1'b1;
  logic        DONE;
  logic [15:0] WR_CNT, CLIP_CNT;

  pixel_plotter #(.H_RES(160), .V_RES(120), .FIFO_DEPTH(4), .ADDR_W(15)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .PIX_VALID(PIX_VALID), .PIX_X(PIX_X),
    .PIX_Y(PIX_Y), .PIX_COLOR(PIX_COLOR), .PIX_LAST(PIX_LAST),
    .PIX_READY(PIX_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA), .MEM_ACK(MEM_ACK), .DONE(DONE),
    .WR_CNT(WR_CNT), .CLIP_CNT(CLIP_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int       addr;
    bit [7:0] data;
    bit       last;
    bit       wr;
  } expT;

  expT  expQ[$];
  int   takenAddr[$];
  int   nTests = 0;
  int   nFail = 0;
  int   mWr = 0, mClip = 0, mDoneCnt = 0, accCount = 0;
  bit   mPrevValid = 0;
  int   mPrevX = 0, mPrevY = 0;
  bit   prevWe = 0, prevReady = 0;
  int   prevAddr = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Acceptance follows from the inputs plus PIX_READY before the edge; everything
  // else is predicted from the clip/duplicate rules and the acceptance order.
  task automatic monitorLoop();
    expT e;
    bit  doneExp, clip, dup, frontOk;
    int  x, y;
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        expQ.delete();
        mPrevValid = 0;
        mWr = 0;
        mClip = 0;
        prevWe = 0;
        prevReady = 0;
      end else begin
        doneExp = 0;
        if (prevWe && MEM_ACK) begin
          takenAddr.push_back(prevAddr);
          if (expQ.size() == 0) begin
            checkOutput("writeOutstanding", 0, 1);
          end else begin
            e = expQ.pop_front();
            checkOutput("takenIsWrite", e.wr, 1);
            doneExp = e.last;
            if (mWr < 65535) mWr++;
          end
        end
        if (DONE) mDoneCnt++;
        if (doneExp) begin
          checkOutput("doneAfterLast", DONE, 1);
        end else if (DONE) begin
          frontOk = (expQ.size() > 0) && !expQ[0].wr;
          checkOutput("doneMarker", frontOk, 1);
          if (frontOk) void'(expQ.pop_front());
        end
        if (MEM_WE) begin
          if (expQ.size() == 0 || !expQ[0].wr) begin
            checkOutput("presentedWrite", 0, 1);
          end else begin
            checkOutput("memAddr", MEM_ADDR, expQ[0].addr);
            checkOutput("memData", MEM_DATA, expQ[0].data);
          end
        end
        if (PIX_VALID && prevReady) begin
          accCount++;
          x = PIX_X;
          y = PIX_Y;
          clip = (x >= HRES) || (y >= VRES);
          dup  = !clip && mPrevValid && (x == mPrevX) && (y == mPrevY);
          if (clip && mClip < 65535) mClip++;
          if (!clip && !dup)
            expQ.push_back('{addr: (y * HRES + x) & 32'h7FFF, data: PIX_COLOR, last: PIX_LAST, wr: 1'b1});
          else if (PIX_LAST)
            expQ.push_back('{addr: 0, data: 8'h00, last: 1'b1, wr: 1'b0});
          mPrevValid = !PIX_LAST;
          mPrevX = x;
          mPrevY = y;
        end
        checkOutput("wrCnt", WR_CNT, mWr);
        checkOutput("clipCnt", CLIP_CNT, mClip);
        prevWe = MEM_WE;
        prevAddr = MEM_ADDR;
        prevReady = PIX_READY;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input int x, input int y, input int color, input bit last);
    int waitCycles = 0;
    PIX_VALID = 1'b1;
    PIX_X = 8'(x);
    PIX_Y = 8'(y);
    PIX_COLOR = 8'(color);
    PIX_LAST = last;
    while (!PIX_READY && waitCycles < 50) begin
      @(negedge ACLK);
      waitCycles++;
    end
    if (!PIX_READY) checkOutput("acceptTimeout", 0, 1);
    @(negedge ACLK);
    PIX_VALID = 1'b0;
    PIX_LAST = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  int wrBase, doneBase, accBase, n;

  initial begin
    fork
      monitorLoop();
      begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
      end
    join_none

    repeat (3) @(negedge ACLK);
    checkOutput("rstMemWe", MEM_WE, 0);
    checkOutput("rstDone", DONE, 0);
    checkOutput("rstReady", PIX_READY, 0);
    checkOutput("rstAddr", MEM_ADDR, 0);
    checkOutput("rstData", MEM_DATA, 0);
    checkOutput("rstWrCnt", WR_CNT, 0);
    checkOutput("rstClipCnt", CLIP_CNT, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("readyAfterReset", PIX_READY, 1);

    // Single in-bounds pixel, 2-cycle latency to MEM_WE.
    applyStimulus(10, 5, 8'h3C, 1'b0);
    checkOutput("lat1MemWe", MEM_WE, 0);
    @(negedge ACLK);
    checkOutput("lat2MemWe", MEM_WE, 1);
    checkOutput("lat2Addr", MEM_ADDR, 810);
    checkOutput("lat2Data", MEM_DATA, 8'h3C);
    @(negedge ACLK);
    checkOutput("firstWrCnt", WR_CNT, 1);
    checkOutput("firstWeLow", MEM_WE, 0);

    // Clipped last pixel: marker only.
    doneBase = mDoneCnt;
    applyStimulus(160, 0, 8'h11, 1'b1);
    checkOutput("clipCnt1", CLIP_CNT, 1);
    @(negedge ACLK);
    checkOutput("clipDone", DONE, 1);
    checkOutput("clipNoWe", MEM_WE, 0);
    idle(3);
    checkOutput("clipDonePulses", mDoneCnt - doneBase, 1);
    checkOutput("clipWrCnt", WR_CNT, 1);
    applyStimulus(5, 120, 8'h22, 1'b0);
    idle(3);
    checkOutput("clipYCnt", CLIP_CNT, 2);
    checkOutput("clipYNoDone", mDoneCnt - doneBase, 1);

    // Duplicate suppression.
    applyStimulus(20, 20, 8'h01, 1'b0);
    applyStimulus(20, 20, 8'h02, 1'b0);
    applyStimulus(21, 20, 8'h03, 1'b0);
    idle(6);
    checkOutput("dupWrCnt", WR_CNT, 3);
    n = takenAddr.size();
    checkOutput("dupAddrA", takenAddr[n-2], 3220);
    checkOutput("dupAddrB", takenAddr[n-1], 3221);

    // Backpressure: one write held plus a full FIFO.
    MEM_ACK = 1'b0;
    accBase = accCount;
    for (int i = 0; i < 5; i++) applyStimulus(30 + i, 40, 8'h40 + i, 1'b0);
    PIX_VALID = 1'b1;
    PIX_X = 8'd35;
    PIX_Y = 8'd40;
    PIX_COLOR = 8'h45;
    idle(3);
    checkOutput("bpReady", PIX_READY, 0);
    checkOutput("bpAccepted", accCount - accBase, 5);
    checkOutput("bpWeHeld", MEM_WE, 1);
    checkOutput("bpAddrHeld", MEM_ADDR, 6430);
    MEM_ACK = 1'b1;
    n = 0;
    while (!PIX_READY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("bpReadyAgain", PIX_READY, 1);
    @(negedge ACLK);
    PIX_VALID = 1'b0;
    idle(10);
    checkOutput("bpWrCnt", WR_CNT, 9);
    n = takenAddr.size();
    for (int i = 0; i < 6; i++) checkOutput("bpOrder", takenAddr[n-6+i], 6430 + i);

    // Rectangle outline (20,20)-(23,22), last pixel tagged.
    doneBase = mDoneCnt;
    for (int x = 20; x <= 23; x++) applyStimulus(x, 20, 8'h77, 1'b0);
    applyStimulus(23, 21, 8'h77, 1'b0);
    for (int x = 23; x >= 20; x--) applyStimulus(x, 22, 8'h77, 1'b0);
    applyStimulus(20, 21, 8'h77, 1'b1);
    idle(6);
    checkOutput("rectWrCnt", WR_CNT, 19);
    checkOutput("rectDone", mDoneCnt - doneBase, 1);

    // Duplicate carrying last, then previous coordinate invalidated; far corner.
    doneBase = mDoneCnt;
    applyStimulus(70, 70, 8'h55, 1'b0);
    applyStimulus(70, 70, 8'h56, 1'b1);
    applyStimulus(70, 70, 8'h57, 1'b0);
    applyStimulus(159, 119, 8'h99, 1'b0);
    idle(6);
    checkOutput("dupLastWrCnt", WR_CNT, 22);
    checkOutput("dupLastDone", mDoneCnt - doneBase, 1);
    checkOutput("cornerAddr", takenAddr[takenAddr.size()-1], 19199);

    // Reset in the middle of a stalled write with 3 entries queued.
    MEM_ACK = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(50 + i, 60, 8'h10 + i, 1'b0);
    idle(1);
    checkOutput("preRstWe", MEM_WE, 1);
    wrBase = takenAddr.size();
    #2 ARESETN = 1'b0;
    #1;
    checkOutput("midRstWe", MEM_WE, 0);
    checkOutput("midRstReady", PIX_READY, 0);
    idle(2);
    checkOutput("midRstWrCnt", WR_CNT, 0);
    checkOutput("midRstClip", CLIP_CNT, 0);
    doneBase = mDoneCnt;
    ARESETN = 1'b1;
    MEM_ACK = 1'b1;
    idle(10);
    checkOutput("postRstWrites", takenAddr.size() - wrBase, 0);
    checkOutput("postRstWrCnt", WR_CNT, 0);
    checkOutput("postRstDone", mDoneCnt - doneBase, 0);
    checkOutput("modelDrained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
